// File: rtl/cpu_div_pkg.sv
// Shared definitions for the CPU's sequential divide cell: state encoding,
// default width and the fixed start-to-done latency used by the stall logic.
package cpu_div_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = DIV_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/cpu_div_step.sv
// One restoring shift-subtract iteration; purely combinational and reused
// every cycle by the divide cell.
module cpu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_diff;

  assign w_shifted = {rem_in, dvd_msb};
  assign w_diff    = w_shifted - {1'b0, divisor};

  // The partial remainder stays below the divisor, so the top bit is a clean borrow
  assign q_bit   = ~w_diff[WIDTH];
  assign rem_out = q_bit ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule

// File: rtl/cpu_div_cell.sv
// Sequential radix-2 restoring divider for div/divu/remainder: one quotient
// bit per clock, results presented with a single-cycle done pulse.
module cpu_div_cell
  import cpu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] E_src1,
  input  logic [WIDTH-1:0] E_src2,
  input  logic             E_div_start,
  input  logic             E_div_signed,
  input  logic             M_kill,
  output logic             M_div_busy,
  output logic             M_div_done,
  output logic [WIDTH-1:0] M_div_quot,
  output logic [WIDTH-1:0] M_div_rem,
  output logic             M_div_by_zero
);

  div_state_e       r_state;
  div_state_e       w_next;

  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_prem;
  logic [WIDTH-1:0] r_src1;
  logic [CNT_W-1:0] r_cnt;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_bz_cap;

  logic [WIDTH-1:0] r_stage_q;
  logic [WIDTH-1:0] r_stage_r;
  logic             r_stage_bz;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_bz;

  logic [WIDTH-1:0] w_abs1;
  logic [WIDTH-1:0] w_abs2;
  logic             w_neg1;
  logic             w_neg2;
  logic             w_accept;
  logic             w_last;
  logic             w_show;
  logic [WIDTH-1:0] w_rem;
  logic             w_qbit;
  logic [WIDTH-1:0] w_qraw;
  logic [WIDTH-1:0] w_qfin;
  logic [WIDTH-1:0] w_rfin;

  cpu_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (r_prem),
    .dvd_msb (r_dvd[WIDTH-1]),
    .divisor (r_dvs),
    .rem_out (w_rem),
    .q_bit   (w_qbit)
  );

  assign w_neg1   = E_div_signed & E_src1[WIDTH-1];
  assign w_neg2   = E_div_signed & E_src2[WIDTH-1];
  assign w_abs1   = w_neg1 ? ('0 - E_src1) : E_src1;
  assign w_abs2   = w_neg2 ? ('0 - E_src2) : E_src2;
  assign w_accept = (r_state == IDLE) && E_div_start && !M_kill;
  assign w_last   = (r_cnt == CNT_W'(1));

  // Final fix-up; divide by zero bypasses the sign handling entirely
  assign w_qraw = {r_dvd[WIDTH-2:0], w_qbit};
  assign w_qfin = r_bz_cap ? '1 : (r_qneg ? ('0 - w_qraw) : w_qraw);
  assign w_rfin = r_bz_cap ? r_src1 : (r_rneg ? ('0 - w_rem) : w_rem);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = ITER;
      ITER: begin
        if (M_kill)      w_next = IDLE;
        else if (w_last) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_prem     <= '0;
      r_src1     <= '0;
      r_cnt      <= '0;
      r_qneg     <= 1'b0;
      r_rneg     <= 1'b0;
      r_bz_cap   <= 1'b0;
      r_stage_q  <= '0;
      r_stage_r  <= '0;
      r_stage_bz <= 1'b0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_bz       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_dvd    <= w_abs1;
            r_dvs    <= w_abs2;
            r_src1   <= E_src1;
            r_prem   <= '0;
            r_cnt    <= CNT_W'(WIDTH);
            r_qneg   <= w_neg1 ^ w_neg2;
            r_rneg   <= w_neg1;
            r_bz_cap <= (E_src2 == '0);
          end
        end
        ITER: begin
          r_prem <= w_rem;
          r_dvd  <= w_qraw;
          r_cnt  <= r_cnt - CNT_W'(1);
          if (w_last) begin
            r_stage_q  <= w_qfin;
            r_stage_r  <= w_rfin;
            r_stage_bz <= r_bz_cap;
          end
        end
        DONE: begin
          // A flush in the done cycle discards the staged results
          if (!M_kill) begin
            r_quot <= r_stage_q;
            r_rem  <= r_stage_r;
            r_bz   <= r_stage_bz;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign w_show        = (r_state == DONE) && !M_kill;
  assign M_div_busy    = (r_state == ITER);
  assign M_div_done    = w_show;
  assign M_div_quot    = w_show ? r_stage_q  : r_quot;
  assign M_div_rem     = w_show ? r_stage_r  : r_rem;
  assign M_div_by_zero = w_show ? r_stage_bz : r_bz;

endmodule

// File: tb/tb_cpu_div_cell.sv
// Scoreboard bench for cpu_div_cell: directed divides push expected results,
// a negedge monitor pops and compares whenever done is presented.
module tb_cpu_div_cell;
  import cpu_div_pkg::*;

  localparam int W = DIV_WIDTH;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] E_src1;
  logic [W-1:0] E_src2;
  logic         E_div_start;
  logic         E_div_signed;
  logic         M_kill;
  logic         M_div_busy;
  logic         M_div_done;
  logic [W-1:0] M_div_quot;
  logic [W-1:0] M_div_rem;
  logic         M_div_by_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         bz;
    int           doneCyc;
    string        name;
  } exp_t;

  exp_t         sbQ[$];
  exp_t         monE;
  int           checks   = 0;
  int           failures = 0;
  int           cyc      = 0;
  logic [W-1:0] lastQ    = '0;
  logic [W-1:0] lastR    = '0;
  logic         lastBz   = 1'b0;

  cpu_div_cell #(.WIDTH(W), .CNT_W(6)) dut (
    .clk           (clk),
    .reset         (reset),
    .E_src1        (E_src1),
    .E_src2        (E_src2),
    .E_div_start   (E_div_start),
    .E_div_signed  (E_div_signed),
    .M_kill        (M_kill),
    .M_div_busy    (M_div_busy),
    .M_div_done    (M_div_done),
    .M_div_quot    (M_div_quot),
    .M_div_rem     (M_div_rem),
    .M_div_by_zero (M_div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (M_div_done === 1'b1) begin
      if (sbQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        monE = sbQ.pop_front();
        checkOutput({monE.name, "_quot"}, M_div_quot, monE.q);
        checkOutput({monE.name, "_rem"}, M_div_rem, monE.r);
        checkOutput({monE.name, "_byzero"}, W'(M_div_by_zero), W'(monE.bz));
        checkOutput({monE.name, "_done_cycle"}, W'(cyc), W'(monE.doneCyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic sg, input logic [W-1:0] eq, input logic [W-1:0] er,
                               input logic ebz, input bit noise);
    int   s;
    int   busyErr;
    exp_t e;
    busyErr = 0;
    tick();
    s = cyc;
    E_src1 = a; E_src2 = b; E_div_signed = sg; E_div_start = 1'b1;
    e.q = eq; e.r = er; e.bz = ebz; e.doneCyc = s + DIV_LATENCY; e.name = name;
    sbQ.push_back(e);
    tick();
    for (int c = s + 1; c <= s + DIV_LATENCY; c++) begin
      E_div_start = noise && (c == s + 5 || c == s + 20);
      if (E_div_start) begin
        E_src1 = 32'h0000_0001; E_src2 = 32'h0000_0001;
      end
      @(negedge clk);
      if (M_div_busy !== (c <= s + W)) busyErr++;
      if (c < s + DIV_LATENCY) tick();
    end
    E_div_start = 1'b0;
    #1;
    checkOutput({name, "_busy_window"}, W'(busyErr), '0);
    checkOutput({name, "_done_seen"}, W'(sbQ.size()), '0);
    lastQ = eq; lastR = er; lastBz = ebz;
  endtask

  task automatic runKillIter();
    int s;
    tick();
    s = cyc;
    E_src1 = 32'd1000; E_src2 = 32'd3; E_div_signed = 1'b0; E_div_start = 1'b1;
    tick();
    E_div_start = 1'b0;
    for (int c = s + 1; c <= s + 40; c++) begin
      M_kill = (c == s + 10);
      @(negedge clk);
      if (c == s + 11) begin
        checkOutput("kill_iter_busy", W'(M_div_busy), '0);
        checkOutput("kill_iter_quot_held", M_div_quot, lastQ);
        checkOutput("kill_iter_rem_held", M_div_rem, lastR);
        checkOutput("kill_iter_byzero_held", W'(M_div_by_zero), W'(lastBz));
      end
      tick();
    end
    M_kill = 1'b0;
  endtask

  task automatic runKillDone();
    int s;
    tick();
    s = cyc;
    E_src1 = 32'd50; E_src2 = 32'd4; E_div_signed = 1'b0; E_div_start = 1'b1;
    tick();
    E_div_start = 1'b0;
    for (int c = s + 1; c <= s + 36; c++) begin
      M_kill = (c == s + DIV_LATENCY);
      @(negedge clk);
      if (c == s + DIV_LATENCY) checkOutput("kill_done_pulse", W'(M_div_done), '0);
      if (c == s + DIV_LATENCY + 1) begin
        checkOutput("kill_done_busy", W'(M_div_busy), '0);
        checkOutput("kill_done_quot_held", M_div_quot, lastQ);
        checkOutput("kill_done_rem_held", M_div_rem, lastR);
      end
      tick();
    end
    M_kill = 1'b0;
  endtask

  task automatic runStartKillIdle();
    int s;
    tick();
    s = cyc;
    E_src1 = 32'd77; E_src2 = 32'd5; E_div_signed = 1'b0; E_div_start = 1'b1; M_kill = 1'b1;
    tick();
    E_div_start = 1'b0; M_kill = 1'b0;
    for (int c = s + 1; c <= s + 36; c++) begin
      @(negedge clk);
      if (c == s + 1) checkOutput("start_kill_idle_busy", W'(M_div_busy), '0);
      tick();
    end
    checkOutput("start_kill_idle_quot_held", M_div_quot, lastQ);
  endtask

  task automatic runResetMidOp();
    int s;
    tick();
    s = cyc;
    E_src1 = 32'd999; E_src2 = 32'd9; E_div_signed = 1'b0; E_div_start = 1'b1;
    tick();
    E_div_start = 1'b0;
    for (int c = s + 1; c <= s + 40; c++) begin
      reset = (c == s + 10);
      @(negedge clk);
      if (c == s + 11) begin
        checkOutput("reset_mid_busy", W'(M_div_busy), '0);
        checkOutput("reset_mid_done", W'(M_div_done), '0);
        checkOutput("reset_mid_quot", M_div_quot, '0);
        checkOutput("reset_mid_rem", M_div_rem, '0);
        checkOutput("reset_mid_byzero", W'(M_div_by_zero), '0);
      end
      tick();
    end
    reset = 1'b0;
    lastQ = '0; lastR = '0; lastBz = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; E_src1 = '0; E_src2 = '0; E_div_start = 1'b0; E_div_signed = 1'b0; M_kill = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", W'(M_div_busy), '0);
    checkOutput("reset_done", W'(M_div_done), '0);
    checkOutput("reset_quot", M_div_quot, '0);
    checkOutput("reset_rem", M_div_rem, '0);
    checkOutput("reset_byzero", W'(M_div_by_zero), '0);
    tick();
    reset = 1'b0;

    applyStimulus("u100_7",    32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        1'b0, 1'b0);
    applyStimulus("sm100_7",   32'hFFFFFF9C, 32'd7,        1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0);
    applyStimulus("s100_m7",   32'd100,      32'hFFFFFFF9, 1'b1, 32'hFFFFFFF2, 32'd2,        1'b0, 1'b0);
    applyStimulus("s_min_m1",  32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        1'b0, 1'b0);
    applyStimulus("u_min_m1",  32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000, 1'b0, 1'b0);
    applyStimulus("s_divzero", 32'h12345678, 32'd0,        1'b1, 32'hFFFFFFFF, 32'h12345678, 1'b1, 1'b0);
    applyStimulus("sm7_2",     32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0);
    applyStimulus("noise_u100_7", 32'd100,   32'd7,        1'b0, 32'd14,       32'd2,        1'b0, 1'b1);
    applyStimulus("b2b_uff_16", 32'hFFFFFFFF, 32'd16,      1'b0, 32'h0FFFFFFF, 32'h0000000F, 1'b0, 1'b0);

    runKillIter();
    runKillDone();
    runStartKillIdle();
    runResetMidOp();

    repeat (2) tick();
    checkOutput("scoreboard_empty", W'(sbQ.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_div_cell.md
Name: cpu_div_cell

Overview:
- Sequential 32-bit integer divider; the inverse-direction companion to the CPU's pipelined 16x16 multiply cell.
- Serves the Nios-style CPU for div, divu, and remainder.
- Accepts operands from the E stage on a start pulse.
- Runs a radix-2 restoring (shift-subtract) iteration, one quotient bit per clock.
- Presents quotient and remainder with a one-cycle done pulse; the CPU stalls on busy.

Parameters:
- WIDTH, 32: operand, quotient and remainder width in bits.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- E_src1  in  WIDTH  dividend.
- E_src2  in  WIDTH  divisor.
- E_div_start  in  1  start request; sampled only in IDLE.
- E_div_signed  in  1  1 = signed (two's complement), 0 = unsigned; captured at start.
- M_kill  in  1  abort current operation (pipeline flush).
- M_div_busy  out  1  high from the cycle after an accepted start until done.
- M_div_done  out  1  single-cycle pulse: results valid.
- M_div_quot  out  WIDTH  quotient; held until next accepted start.
- M_div_rem  out  WIDTH  remainder; held until next accepted start.
- M_div_by_zero  out  1  divisor was zero; valid with done, held like results.

Behaviour:
- Reset: state IDLE. busy=0, done=0, quot=0, rem=0, by_zero=0, counter=0. Reset overrides every other input in the same cycle, including mid-operation.
- States: IDLE, ITER, DONE.
- IDLE:
  - If E_div_start=1 at an edge, capture operands: |src1| and |src2| when signed, raw values otherwise.
  - Also capture the quotient sign (signed AND sign(src1) XOR sign(src2)), the remainder sign (signed AND sign(src1)), and by_zero = (src2==0).
  - Clear the partial remainder, load counter=WIDTH, go to ITER.
- ITER:
  - Each cycle, shift {rem, dividend} left by 1 and trial-subtract the divisor (WIDTH+1-bit subtract).
  - If the difference is non-negative, the new rem is the difference and the quotient bit is 1; otherwise rem is kept and the bit is 0.
  - Decrement the counter. After WIDTH iterations go to DONE.
- DONE: one cycle only.
  - Register final quot and rem, applying two's-complement negation per the captured signs.
  - Assert done=1, deassert busy, return to IDLE.
- Latency: start accepted at edge N; busy high in cycles N+1..N+WIDTH; done high in cycle N+WIDTH+1 (33 cycles for WIDTH=32). Results appear in the same cycle as done.
- Back-to-back operation: the earliest next start is sampled in the cycle after done.
- Start while busy or in DONE: ignored, no queueing.
- M_kill in ITER or DONE: next state IDLE, busy=0, no done pulse, quot/rem/by_zero keep their previous values. M_kill in IDLE has no effect; start and kill together in IDLE means kill wins and start is dropped.
- Divide by zero (no exception):
  - Quotient = all ones, remainder = raw E_src1 (unsigned), with sign fix-up suppressed.
  - by_zero=1.
  - Normal latency.
- Signed overflow (MIN / -1): quotient = MIN (0x80000000), remainder = 0, by_zero=0. This falls out of unsigned |MIN|=2^31 and negation wrap.
- Sign rules: quotient truncates toward zero; a nonzero remainder takes the sign of the dividend; magnitude(rem) < magnitude(divisor).
- Arithmetic: all internal datapaths are WIDTH bits, except the trial subtract at WIDTH+1. Negation is modulo 2^WIDTH.

Decomposition:
- Shared package cpu_div_pkg:
  - state enum {IDLE, ITER, DONE};
  - DIV_WIDTH=32;
  - DIV_LATENCY = DIV_WIDTH+1, for the CPU stall logic and the bench.
- One sub-module, cpu_div_step: purely combinational single restoring iteration (rem_in, dvd_msb, divisor -> rem_out, q_bit). It is instantiated once and reused every cycle; it is not unrolled.

Test Plan:
- Unsigned 100 / 7, start at cycle 0 -> done only in cycle 33; quot=14, rem=2, by_zero=0; busy high cycles 1..32.
- Signed -100 (0xFFFFFF9C) / 7 -> quot=0xFFFFFFF2 (-14), rem=0xFFFFFFFE (-2). Signed 100 / -7 -> quot=0xFFFFFFF2, rem=2.
- 0x80000000 / 0xFFFFFFFF:
  - signed -> quot=0x80000000, rem=0.
  - unsigned -> quot=0, rem=0x80000000.
- Divide by zero, 0x12345678 / 0, signed -> quot=0xFFFFFFFF, rem=0x12345678, by_zero=1, done at cycle 33.
- Start pulses in cycles 5 and 20 during an operation -> ignored; exactly one done, at cycle 33. A new start at cycle 34 -> done at cycle 67.
- Kill and reset:
  - M_kill at cycle 10 -> IDLE at cycle 11, no done, previous results held.
  - reset at cycle 10 of a fresh operation -> all outputs 0 in cycle 11.
  - start and kill together in IDLE -> no operation starts.
